// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared types and helpers for the parametrised execute stage.
//   opcode_e   : 4-bit opcode map; codes 0-7 match the original 8-bit unit
//   state_e    : execute-stage FSM states
//   is_mem_op  : true for the two opcodes that use the data-memory port
//   is_jump_op : true for the four jump opcodes
//   jump_taken : branch decision; the caller reduces reg1 to zero/sign flags
//                so the helper stays independent of the data width
// ---------------------------------------------------------------------------
package exec_pkg;

  typedef enum logic [3:0] {
    OP_JMP  = 4'd0,
    OP_LOD  = 4'd1,
    OP_STR  = 4'd2,
    OP_ADD  = 4'd3,
    OP_ADDI = 4'd4,
    OP_LODI = 4'd5,
    OP_NAND = 4'd6,
    OP_JEQZ = 4'd7,
    OP_SUB  = 4'd8,
    OP_AND  = 4'd9,
    OP_OR   = 4'd10,
    OP_XOR  = 4'd11,
    OP_SHL  = 4'd12,
    OP_SHR  = 4'd13,
    OP_JNEZ = 4'd14,
    OP_JLTZ = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DONE     = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

  function automatic logic is_jump_op(input opcode_e op);
    return (op == OP_JMP) || (op == OP_JEQZ) || (op == OP_JNEZ) || (op == OP_JLTZ);
  endfunction

  // reg1_zero: reg1 == 0, reg1_neg: most significant bit of reg1
  function automatic logic jump_taken(input opcode_e op, input logic reg1_zero,
                                      input logic reg1_neg);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JEQZ: taken = reg1_zero;
      OP_JNEZ: taken = ~reg1_zero;
      OP_JLTZ: taken = reg1_neg;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
// Purely combinational datapath for the execute stage. Kept free of any
// sequencing so a second issue slot can reuse it unchanged.
//   op     in  4       opcode (exec_pkg::opcode_e encoding)
//   a      in  DATA_W  first source (reg0)
//   b      in  DATA_W  second source (reg1); low log2(DATA_W) bits = shift amount
//   imm    in  DATA_W  immediate
//   result out DATA_W  ALU result; 0 for memory and jump opcodes
// ---------------------------------------------------------------------------
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  // All arithmetic wraps modulo 2^DATA_W; no flags are produced.
  always_comb begin
    result = '0;
    case (opcode_e'(op))
      OP_ADD:  result = a + b;
      OP_ADDI: result = a + imm;
      OP_LODI: result = imm;
      OP_NAND: result = ~(a & b);
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit_p.sv
// ---------------------------------------------------------------------------
// exec_unit_p
// Parametrised execute stage: ALU ops, conditional jumps and a data-memory
// handshake with optional timeout, sequenced by a four-state FSM.
//   clk, rst        clock and synchronous active-high reset
//   en              instruction valid, held by the pipeline until ready
//   op, reg0, reg1, imm   decoded instruction and operands
//   mem_data_in, mem_ready  memory read data and completion
//   pc_out          jump target (held)
//   val_out         writeback result (held)
//   mem_addr, mem_data_out, mem_we   memory request fields (held)
//   mem_req         memory request level
//   flush_pipeline  one-cycle pulse on a taken jump
//   mem_err         one-cycle pulse on memory timeout
//   ready           one-cycle completion pulse
// ---------------------------------------------------------------------------
module exec_unit_p
  import exec_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] reg0,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic              flush_pipeline,
  output logic              mem_err,
  output logic              ready
);

  // Counter only needs to reach MEM_TIMEOUT-1; with timeout disabled it
  // simply wraps and is never compared.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TMO_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_I[CNT_W-1:0];
  localparam logic TMO_EN = (MEM_TIMEOUT != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               req_q, req_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  opcode_e            op_e;
  logic [DATA_W-1:0]  alu_res;
  logic [ADDR_W-1:0]  jump_tgt;
  logic [ADDR_W-1:0]  mem_tgt;
  logic               taken;

  assign op_e = opcode_e'(op);

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (reg0),
    .b      (reg1),
    .imm    (imm),
    .result (alu_res)
  );

  // Adding only the low ADDR_W bits gives the same result as truncating the
  // full-width sum.
  assign jump_tgt = imm[ADDR_W-1:0] + reg0[ADDR_W-1:0];
  assign mem_tgt  = reg1[ADDR_W-1:0] + imm[ADDR_W-1:0];
  assign taken    = jump_taken(op_e, (reg1 == '0), reg1[DATA_W-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    flush_d = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b0;

    // Dropping en aborts whatever is in flight, including a memory request.
    if (!en) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem_op(op_e)) begin
            addr_d  = mem_tgt;
            wdata_d = reg0;
            we_d    = (op_e == OP_STR);
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_MEM_WAIT;
          end else begin
            if (is_jump_op(op_e)) begin
              if (taken) begin
                pc_d    = jump_tgt;
                flush_d = 1'b1;
              end
            end else begin
              val_d = alu_res;
            end
            state_d = ST_DONE;
          end
        end

        // Read data is captured for stores too; writeback ignores it.
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            req_d   = 1'b0;
            val_d   = mem_data_in;
            state_d = ST_DONE;
          end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
            req_d   = 1'b0;
            val_d   = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          ready_d = 1'b1;
          state_d = ST_HOLD;
        end

        // Parked until the pipeline lowers en, so an instruction held on
        // the bus never executes twice.
        ST_HOLD: begin
          state_d = ST_HOLD;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign pc_out         = pc_q;
  assign val_out        = val_q;
  assign mem_addr       = addr_q;
  assign mem_data_out   = wdata_q;
  assign mem_we         = we_q;
  assign mem_req        = req_q;
  assign flush_pipeline = flush_q;
  assign mem_err        = err_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_exec_unit_p.sv
// ---------------------------------------------------------------------------
// tb_exec_unit_p
// Directed bench for exec_unit_p at DATA_W=16, ADDR_W=8, MEM_TIMEOUT=4.
// Expected writeback/pc values are queued when an instruction is driven and
// popped when the unit raises ready.
// ---------------------------------------------------------------------------
module tb_exec_unit_p;
  import exec_pkg::*;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int MEM_TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic [3:0]        op;
  logic [DATA_W-1:0] reg0;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;
  logic [ADDR_W-1:0] pc_out;
  logic [DATA_W-1:0] val_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_req;
  logic              mem_we;
  logic              flush_pipeline;
  logic              mem_err;
  logic              ready;

  exec_unit_p #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .op             (op),
    .reg0           (reg0),
    .reg1           (reg1),
    .imm            (imm),
    .mem_data_in    (mem_data_in),
    .mem_ready      (mem_ready),
    .pc_out         (pc_out),
    .val_out        (val_out),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .flush_pipeline (flush_pipeline),
    .mem_err        (mem_err),
    .ready          (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
    logic [7:0]  pc;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] im;
    logic [15:0] res;
  } alu_vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] im;
    logic        taken;
    logic [7:0]  pc;
  } jmp_vec_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_val;
  logic [7:0]  exp_pc;
  alu_vec_t    alu_tab[9];
  jmp_vec_t    jmp_tab[7];

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] r0,
                               input logic [15:0] r1, input logic [15:0] im);
    en   = 1'b1;
    op   = o;
    reg0 = r0;
    reg1 = r1;
    imm  = im;
  endtask

  task automatic dropEnable();
    en = 1'b0;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pushExpect(input string tag);
    exp_t e;
    e.tag = tag;
    e.val = exp_val;
    e.pc  = exp_pc;
    sb.push_back(e);
  endtask

  task automatic popCompare();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: observed ready with empty queue, expected a queued result");
    end else begin
      e = sb.pop_front();
      checkOutput({e.tag, "_val"}, 32'(val_out), 32'(e.val));
      checkOutput({e.tag, "_pc"},  32'(pc_out),  32'(e.pc));
    end
  endtask

  // Bounded wait for the ready pulse; an expired budget is a failed check.
  task automatic waitReady(input string tag, input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    if (ready === 1'b1) popCompare();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    alu_tab = '{
      '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030},
      '{OP_OR,   16'hF0F0, 16'h0F01, 16'h0000, 16'hFFF1},
      '{OP_XOR,  16'hFF00, 16'h0FF0, 16'h0000, 16'hF0F0},
      '{OP_NAND, 16'hFF00, 16'h0FF0, 16'h0000, 16'hF0FF},
      '{OP_SHR,  16'h8000, 16'h0024, 16'h0000, 16'h0800},
      '{OP_ADDI, 16'hFFFF, 16'h0000, 16'h0003, 16'h0002},
      '{OP_LODI, 16'h0000, 16'h0000, 16'h1234, 16'h1234},
      '{OP_ADD,  16'h7FFF, 16'h0001, 16'h0000, 16'h8000},
      '{OP_SHL,  16'h0001, 16'h000F, 16'h0000, 16'h8000}
    };
    jmp_tab = '{
      '{OP_JLTZ, 16'h0002, 16'h8000, 16'h0010, 1'b1, 8'h12},
      '{OP_JNEZ, 16'h0007, 16'h0000, 16'h0007, 1'b0, 8'h00},
      '{OP_JMP,  16'h0005, 16'h0001, 16'h0100, 1'b1, 8'h05},
      '{OP_JEQZ, 16'h0010, 16'h0000, 16'h0020, 1'b1, 8'h30},
      '{OP_JEQZ, 16'h0001, 16'h0001, 16'h0001, 1'b0, 8'h00},
      '{OP_JNEZ, 16'h0001, 16'h0100, 16'h0001, 1'b1, 8'h02},
      '{OP_JLTZ, 16'h0003, 16'h7FFF, 16'h0003, 1'b0, 8'h00}
    };

    // Reset held for two edges with a valid ADD on the bus.
    rst         = 1'b1;
    mem_ready   = 1'b0;
    mem_data_in = '0;
    applyStimulus(OP_ADD, 16'h0001, 16'h0002, 16'h0000);
    tick();
    tick();
    checkOutput("rst_pc",    32'(pc_out),         32'd0);
    checkOutput("rst_val",   32'(val_out),        32'd0);
    checkOutput("rst_addr",  32'(mem_addr),       32'd0);
    checkOutput("rst_wdata", 32'(mem_data_out),   32'd0);
    checkOutput("rst_req",   32'(mem_req),        32'd0);
    checkOutput("rst_we",    32'(mem_we),         32'd0);
    checkOutput("rst_flush", 32'(flush_pipeline), 32'd0);
    checkOutput("rst_err",   32'(mem_err),        32'd0);
    checkOutput("rst_ready", 32'(ready),          32'd0);

    // First instruction after release executes normally.
    rst     = 1'b0;
    exp_val = 16'h0003;
    exp_pc  = 8'h00;
    pushExpect("post_rst_add");
    tick();
    checkOutput("post_rst_add_edgeN_val", 32'(val_out), 32'h3);
    checkOutput("post_rst_add_edgeN_rdy", 32'(ready), 32'd0);
    waitReady("post_rst_add", 1);
    tick();
    checkOutput("post_rst_add_hold", 32'(ready), 32'd0);
    dropEnable();

    // SUB wraps below zero; ready stays low while en is held.
    applyStimulus(OP_SUB, 16'h0003, 16'h0005, 16'h0000);
    exp_val = 16'hFFFE;
    pushExpect("sub");
    tick();
    checkOutput("sub_edgeN_val", 32'(val_out), 32'hFFFE);
    checkOutput("sub_edgeN_rdy", 32'(ready), 32'd0);
    waitReady("sub", 1);
    tick();
    checkOutput("sub_hold1", 32'(ready), 32'd0);
    tick();
    checkOutput("sub_hold2", 32'(ready), 32'd0);
    dropEnable();

    // SHL uses only reg1[3:0]: 0x13 shifts by 3.
    applyStimulus(OP_SHL, 16'h0001, 16'h0013, 16'h0000);
    exp_val = 16'h0008;
    pushExpect("shl");
    waitReady("shl", 4);
    dropEnable();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(alu_tab[i].op, alu_tab[i].r0, alu_tab[i].r1, alu_tab[i].im);
      exp_val = alu_tab[i].res;
      pushExpect($sformatf("alu%0d", i));
      tick();
      checkOutput($sformatf("alu%0d_edgeN_val", i), 32'(val_out), 32'(exp_val));
      waitReady($sformatf("alu%0d", i), 2);
      dropEnable();
    end

    // Jumps: val_out must keep the last ALU result throughout.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(jmp_tab[i].op, jmp_tab[i].r0, jmp_tab[i].r1, jmp_tab[i].im);
      if (jmp_tab[i].taken) exp_pc = jmp_tab[i].pc;
      pushExpect($sformatf("jmp%0d", i));
      tick();
      checkOutput($sformatf("jmp%0d_flush", i), 32'(flush_pipeline), 32'(jmp_tab[i].taken));
      checkOutput($sformatf("jmp%0d_pc", i), 32'(pc_out), 32'(exp_pc));
      tick();
      checkOutput($sformatf("jmp%0d_flush_off", i), 32'(flush_pipeline), 32'd0);
      checkOutput($sformatf("jmp%0d_ready", i), 32'(ready), 32'd1);
      if (ready === 1'b1) popCompare();
      dropEnable();
    end

    // LOD with address wrap; memory answers on the third wait edge.
    applyStimulus(OP_LOD, 16'h0000, 16'h00F0, 16'h0020);
    exp_val = 16'h005A;
    pushExpect("lod");
    tick();
    checkOutput("lod_req",  32'(mem_req),  32'd1);
    checkOutput("lod_addr", 32'(mem_addr), 32'h10);
    checkOutput("lod_we",   32'(mem_we),   32'd0);
    tick();
    checkOutput("lod_wait1_req", 32'(mem_req), 32'd1);
    tick();
    checkOutput("lod_wait2_req", 32'(mem_req), 32'd1);
    mem_ready   = 1'b1;
    mem_data_in = 16'h005A;
    tick();
    mem_ready = 1'b0;
    checkOutput("lod_req_drop", 32'(mem_req), 32'd0);
    checkOutput("lod_val",      32'(val_out), 32'h5A);
    checkOutput("lod_rdy_early", 32'(ready),  32'd0);
    waitReady("lod", 1);
    dropEnable();

    // STR with no response: request held 4 cycles, then error.
    applyStimulus(OP_STR, 16'hBEEF, 16'h0001, 16'h0002);
    exp_val = 16'h0000;
    pushExpect("str_tmo");
    tick();
    checkOutput("str_we",    32'(mem_we),       32'd1);
    checkOutput("str_addr",  32'(mem_addr),     32'h03);
    checkOutput("str_wdata", 32'(mem_data_out), 32'hBEEF);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("str_req_c%0d", i), 32'(mem_req), 32'd1);
      tick();
      checkOutput($sformatf("str_err_c%0d", i), 32'(mem_err), 32'd0);
    end
    checkOutput("str_req_c4", 32'(mem_req), 32'd1);
    tick();
    checkOutput("str_tmo_req", 32'(mem_req), 32'd0);
    checkOutput("str_tmo_err", 32'(mem_err), 32'd1);
    checkOutput("str_tmo_val", 32'(val_out), 32'd0);
    tick();
    checkOutput("str_err_pulse", 32'(mem_err), 32'd0);
    checkOutput("str_tmo_ready", 32'(ready), 32'd1);
    if (ready === 1'b1) popCompare();
    dropEnable();

    // Abort a LOD in MEM_WAIT; a late mem_ready must be ignored.
    applyStimulus(OP_LOD, 16'h0000, 16'h0040, 16'h0000);
    tick();
    checkOutput("abort_req_on", 32'(mem_req), 32'd1);
    tick();
    en = 1'b0;
    tick();
    checkOutput("abort_req_off", 32'(mem_req), 32'd0);
    checkOutput("abort_no_rdy",  32'(ready),   32'd0);
    mem_ready   = 1'b1;
    mem_data_in = 16'hAAAA;
    tick();
    mem_ready = 1'b0;
    checkOutput("late_rdy_val",   32'(val_out), 32'd0);
    checkOutput("late_rdy_ready", 32'(ready),   32'd0);

    applyStimulus(OP_LOD, 16'h0000, 16'h0005, 16'h0001);
    exp_val = 16'h00C3;
    pushExpect("lod2");
    tick();
    checkOutput("lod2_addr", 32'(mem_addr), 32'h06);
    checkOutput("lod2_req",  32'(mem_req),  32'd1);
    mem_ready   = 1'b1;
    mem_data_in = 16'h00C3;
    tick();
    mem_ready = 1'b0;
    waitReady("lod2", 2);
    dropEnable();

    // Reset in the middle of a memory access clears everything.
    applyStimulus(OP_LOD, 16'h0000, 16'h0009, 16'h0000);
    tick();
    checkOutput("midrst_req_on", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_req",  32'(mem_req),  32'd0);
    checkOutput("midrst_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_val",  32'(val_out),  32'd0);
    checkOutput("midrst_pc",   32'(pc_out),   32'd0);
    rst = 1'b0;
    dropEnable();
    checkOutput("midrst_idle_rdy", 32'(ready), 32'd0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exec_unit_p.md
Name: exec_unit_p

Overview:
Parametrised execute stage for the bf8b-style pipeline, the successor to the fixed 8-bit execute unit. It is generalised in data width and address width. It fills the spare opcode space with SUB, AND, OR, XOR, shifts and extra conditional jumps, and replaces the ad-hoc cycle counter with an explicit FSM. It adds a bounded memory handshake with timeout and error reporting. It sits between decode/register-read and writeback and owns the data-memory request port.

Parameters:
DATA_W, 8, register/immediate/result width (power of two, ≥8)
ADDR_W, 8, data-memory address and PC width (≤ DATA_W)
MEM_TIMEOUT, 0, cycles to wait for mem_ready before erroring; 0 = wait forever

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  instruction valid; held high by the pipeline until ready is seen
op  in  4  opcode
reg0  in  DATA_W  first source / store data
reg1  in  DATA_W  second source / base address / jump condition
imm  in  DATA_W  immediate
mem_data_in  in  DATA_W  read data
mem_ready  in  1  memory completion
pc_out  out  ADDR_W  jump target
val_out  out  DATA_W  result for writeback
mem_addr  out  ADDR_W  memory address
mem_data_out  out  DATA_W  store data
mem_req  out  1  memory request, level
mem_we  out  1  write enable, qualified by mem_req
flush_pipeline  out  1  taken-jump pulse
mem_err  out  1  memory timeout pulse
ready  out  1  completion pulse

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and the timeout counter is 0. rst overrides en, including mid-operation.
- FSM states: IDLE, MEM_WAIT, DONE, HOLD.
- Opcodes 0–7 are binary compatible with the 8-bit unit: 0 JMP, 1 LOD, 2 STR, 3 ADD, 4 ADDI, 5 LODI, 6 NAND, 7 JEQZ.
- New opcodes:
  - 8 SUB: reg0 − reg1
  - 9 AND
  - 10 OR
  - 11 XOR
  - 12 SHL: reg0 << reg1[log2(DATA_W)−1:0]
  - 13 SHR: logical shift right, same shift amount
  - 14 JNEZ: taken if reg1 ≠ 0
  - 15 JLTZ: taken if reg1[DATA_W−1] = 1
- Arithmetic is modulo 2^DATA_W with no flags. Jump target = (imm + reg0)[ADDR_W−1:0]. Memory address = (reg1 + imm)[ADDR_W−1:0].
- IDLE, en = 1, non-memory op, edge N:
  - ALU ops write val_out.
  - Taken jumps write pc_out and set flush_pipeline = 1.
  - Untaken jumps change neither val_out nor pc_out.
  - FSM goes to DONE.
- DONE, edge N+1: ready = 1 and flush_pipeline = 0, so flush is exactly one cycle. FSM goes to HOLD. ALU latency is 2 edges, matching the 8-bit unit.
- IDLE, en = 1, LOD/STR, edge N: mem_addr, mem_data_out = reg0, mem_we = (op == STR), mem_req = 1. FSM goes to MEM_WAIT and the timeout counter clears.
- MEM_WAIT, each edge:
  - If mem_ready = 1: mem_req = 0 and val_out = mem_data_in (captured for STR too; writeback ignores it). FSM goes to DONE.
  - Else if MEM_TIMEOUT ≠ 0 and the counter equals MEM_TIMEOUT−1: mem_req = 0, val_out = 0, mem_err = 1 for one cycle. FSM goes to DONE.
  - Else the counter increments.
- mem_ready seen in IDLE, DONE or HOLD is ignored.
- HOLD: ready = 0. Stays in HOLD while en = 1, so one instruction never executes twice. en = 0 returns the FSM to IDLE.
- en = 0 in any state on an edge: FSM goes to IDLE, and mem_req, ready, flush_pipeline and mem_err clear. This aborts an outstanding memory access; the memory must tolerate a dropped request.
- A new instruction can be accepted no earlier than the edge after the one where en was seen low.
- val_out, pc_out, mem_addr, mem_data_out and mem_we hold their last values when not being written.

Decomposition:
- Package exec_pkg holds:
  - the 4-bit opcode enum (all 16 codes)
  - the FSM state enum
  - a function is_mem_op(op)
  - a function jump_taken(op, reg1)
- One combinational sub-module, exec_alu (op, a, b, imm → result), keeps the datapath separate from the FSM and is reusable by a future second issue slot.

Test Plan:
1. Reset: assert rst for 2 cycles while en = 1 with op = ADD → all outputs 0. First en after release executes normally.
2. ALU: DATA_W = 16, SUB reg0 = 0x0003, reg1 = 0x0005 → val_out = 0xFFFE at edge N, ready pulse at N+1, ready low while en is held. Also SHL reg0 = 0x0001, reg1 = 0x0013 → shift 3 → 0x0008.
3. Jumps:
   - JLTZ reg1 = 0x80, imm = 0x10, reg0 = 0x02 → pc_out = 0x12, flush for exactly 1 cycle.
   - JNEZ reg1 = 0 → no flush, pc_out unchanged, ready still pulses.
4. LOD: reg1 = 0xF0, imm = 0x20 → mem_addr = 0x10 (wrap). mem_ready after 3 wait cycles with data 0x5A → val_out = 0x5A, mem_req drops on the same edge, ready on the next edge.
5. Timeout: MEM_TIMEOUT = 4, STR with mem_ready tied low → mem_req high for 4 cycles, mem_err and val_out = 0, then a ready pulse.
6. Abort: drop en in MEM_WAIT → mem_req clears next edge, no ready. A late mem_ready pulse is ignored. The next LOD completes correctly.
